// File: rtl/alu_cmd_sequencer_if.sv
// Handshake and ALU bus bundle for alu_cmd_sequencer.
// master is the sequencer's view; slave is the command source, ALU and result consumer.
interface alu_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_opcode;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [3:0] alu_opcode;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_en;
    logic [7:0] alu_result;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [3:0] res_opcode;
    logic       res_err;
    logic [2:0] res_count;

    modport master (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_result, res_ready,
        output cmd_ready, alu_opcode, alu_a, alu_b, alu_en,
               res_valid, res_data, res_opcode, res_err, res_count
    );

    modport slave (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_result, res_ready,
        input  cmd_ready, alu_opcode, alu_a, alu_b, alu_en,
               res_valid, res_data, res_opcode, res_err, res_count
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issues one ALU operation at a time, captures the result after ALU_LATENCY cycles,
// and queues results (or error entries for rejected commands) in a FWFT FIFO.
module alu_cmd_sequencer #(
    parameter int unsigned ALU_LATENCY = 1,
    parameter int unsigned RES_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset,
    alu_cmd_sequencer_if.master bus
);
    localparam int unsigned AW      = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam logic [2:0]  DEPTH_C = 3'(RES_DEPTH);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, REJECT} state_e;

    state_e        state_q;
    logic [3:0]    op_q;
    logic [3:0]    alu_op_q;
    logic [7:0]    alu_a_q;
    logic [7:0]    alu_b_q;
    logic          alu_en_q;
    logic [2:0]    wait_q;

    logic [7:0]    mem_data_q [RES_DEPTH];
    logic [3:0]    mem_op_q   [RES_DEPTH];
    logic          mem_err_q  [RES_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [2:0]    count_q;
    logic [7:0]    last_data_q;
    logic [3:0]    last_op_q;
    logic          last_err_q;

    logic          cmd_ready;
    logic          accept;
    logic          illegal;
    logic          capture;
    logic          push;
    logic          pop;
    logic          empty;

    assign empty     = (count_q == 3'd0);
    assign cmd_ready = !reset && (state_q == IDLE) && (count_q < DEPTH_C);
    assign accept    = bus.cmd_valid && cmd_ready;
    assign illegal   = (bus.cmd_opcode > 4'd8) ||
                       ((bus.cmd_opcode == 4'd3) && (bus.cmd_b == 8'h00));
    // The result is sampled on the edge that moves WAIT into CAPTURE, i.e. exactly
    // ALU_LATENCY edges after the alu_en edge; CAPTURE then only returns to IDLE.
    assign capture   = (state_q == WAIT) && (wait_q == 3'd1);
    assign push      = capture || (state_q == REJECT);
    assign pop       = !empty && bus.res_ready;

    assign bus.cmd_ready  = cmd_ready;
    assign bus.alu_opcode = alu_op_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_en     = alu_en_q;
    assign bus.res_valid  = !empty;
    assign bus.res_data   = empty ? last_data_q : mem_data_q[rd_ptr_q];
    assign bus.res_opcode = empty ? last_op_q   : mem_op_q[rd_ptr_q];
    assign bus.res_err    = empty ? last_err_q  : mem_err_q[rd_ptr_q];
    assign bus.res_count  = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_en_q <= 1'b0;
            wait_q   <= '0;
        end else begin
            alu_en_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q <= bus.cmd_opcode;
                        if (illegal) begin
                            state_q <= REJECT;
                        end else begin
                            state_q  <= ISSUE;
                            alu_op_q <= bus.cmd_opcode;
                            alu_a_q  <= bus.cmd_a;
                            alu_b_q  <= bus.cmd_b;
                            alu_en_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                    wait_q  <= 3'(ALU_LATENCY);
                end
                WAIT: begin
                    if (wait_q == 3'd1) state_q <= CAPTURE;
                    else                wait_q  <= wait_q - 3'd1;
                end
                CAPTURE, REJECT: state_q <= IDLE;
                default:         state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < RES_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_op_q[i]   <= '0;
                mem_err_q[i]  <= 1'b0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_data_q <= '0;
            last_op_q   <= '0;
            last_err_q  <= 1'b0;
        end else begin
            if (push) begin
                mem_data_q[wr_ptr_q] <= capture ? bus.alu_result : 8'h00;
                mem_op_q[wr_ptr_q]   <= op_q;
                mem_err_q[wr_ptr_q]  <= !capture;
                wr_ptr_q             <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                last_data_q <= mem_data_q[rd_ptr_q];
                last_op_q   <= mem_op_q[rd_ptr_q];
                last_err_q  <= mem_err_q[rd_ptr_q];
                rd_ptr_q    <= rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a latency-1 behavioural ALU attached.
module tb_alu_cmd_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   en_cnt = 0;
    logic       acc_set = 1'b0;
    logic [7:0] acc_val = 8'h00;
    logic [7:0] acc;

    alu_cmd_sequencer_if bus ();

    alu_cmd_sequencer #(.ALU_LATENCY(1), .RES_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: result registered on the alu_en edge.
    always @(posedge clk) begin
        logic [7:0] r;
        logic [7:0] na;
        if (reset) begin
            bus.alu_result <= 8'h00;
            acc <= 8'h00;
        end else if (acc_set) begin
            acc <= acc_val;
        end else if (bus.alu_en) begin
            en_cnt <= en_cnt + 1;
            na = acc;
            case (bus.alu_opcode)
                4'd0: r = bus.alu_a + bus.alu_b;
                4'd1: r = bus.alu_a - bus.alu_b;
                4'd2: r = bus.alu_a * bus.alu_b;
                4'd3: r = bus.alu_a / bus.alu_b;
                4'd4: begin na = acc + bus.alu_a; r = na; end
                4'd5: begin na = acc * bus.alu_a; r = na; end
                4'd6: begin na = acc + bus.alu_a * bus.alu_b; r = na; end
                4'd7: r = {bus.alu_a[6:0], bus.alu_a[7]};
                4'd8: r = {bus.alu_a[0], bus.alu_a[7:1]};
                default: r = 8'h00;
            endcase
            acc <= na;
            bus.alu_result <= r;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command for a single accepted cycle, then waits for a result.
    task automatic run_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           output logic ok);
        int n;
        ok = 1'b0;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin tick(); n++; end
        bus.cmd_opcode = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.res_valid && n < 20) begin tick(); n++; end
        ok = bus.res_valid;
    endtask

    task automatic pop_one();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_opcode = 4'd0; bus.cmd_a = 8'h00; bus.cmd_b = 8'h00;
        bus.res_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.alu_en, bus.alu_opcode, bus.alu_a, bus.alu_b} !== 21'd0) begin
            failures++;
            $display("FAIL reset_alu: got en=%b op=%h a=%h b=%h, want all 0",
                     bus.alu_en, bus.alu_opcode, bus.alu_a, bus.alu_b);
        end
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
            failures++; $display("FAIL reset_cmd_ready: got %b want 0", bus.cmd_ready);
        end
        checks++;
        if ({bus.res_valid, bus.res_data, bus.res_opcode, bus.res_err, bus.res_count} !== 17'd0) begin
            failures++;
            $display("FAIL reset_res: got v=%b d=%h op=%h err=%b cnt=%0d, want all 0",
                     bus.res_valid, bus.res_data, bus.res_opcode, bus.res_err, bus.res_count);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++; $display("FAIL release_cmd_ready: got %b want 1", bus.cmd_ready);
        end
    endtask

    task automatic test_add();
        bus.cmd_opcode = 4'd0; bus.cmd_a = 8'h0A; bus.cmd_b = 8'h05; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if ({bus.alu_en, bus.alu_opcode, bus.alu_a, bus.alu_b, bus.cmd_ready} !== {1'b1, 4'd0, 8'h0A, 8'h05, 1'b0}) begin
            failures++;
            $display("FAIL add_issue: got en=%b op=%h a=%h b=%h rdy=%b, want 1 0 0a 05 0",
                     bus.alu_en, bus.alu_opcode, bus.alu_a, bus.alu_b, bus.cmd_ready);
        end
        tick();
        checks++;
        if ({bus.alu_en, bus.res_valid} !== 2'b00) begin
            failures++;
            $display("FAIL add_wait: got en=%b res_valid=%b want 0 0", bus.alu_en, bus.res_valid);
        end
        tick();
        checks++;
        if ({bus.res_valid, bus.res_data, bus.res_opcode, bus.res_err, bus.res_count} !== {1'b1, 8'h0F, 4'd0, 1'b0, 3'd1}) begin
            failures++;
            $display("FAIL add_result: got v=%b d=%h op=%h err=%b cnt=%0d, want 1 0f 0 0 1",
                     bus.res_valid, bus.res_data, bus.res_opcode, bus.res_err, bus.res_count);
        end
        pop_one();
        checks++;
        if ({bus.res_valid, bus.res_count, bus.res_data} !== {1'b0, 3'd0, 8'h0F}) begin
            failures++;
            $display("FAIL add_pop_hold: got v=%b cnt=%0d d=%h, want 0 0 0f",
                     bus.res_valid, bus.res_count, bus.res_data);
        end
    endtask

    task automatic test_reject();
        int en0;
        en0 = en_cnt;
        bus.cmd_opcode = 4'd3; bus.cmd_a = 8'h08; bus.cmd_b = 8'h00; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        checks++;
        if ({bus.alu_en, bus.alu_opcode, bus.alu_a, bus.alu_b} !== {1'b0, 4'd0, 8'h0A, 8'h05}) begin
            failures++;
            $display("FAIL div0_alu_untouched: got en=%b op=%h a=%h b=%h, want 0 0 0a 05",
                     bus.alu_en, bus.alu_opcode, bus.alu_a, bus.alu_b);
        end
        tick();
        checks++;
        if ({bus.res_valid, bus.res_data, bus.res_opcode, bus.res_err} !== {1'b1, 8'h00, 4'd3, 1'b1}) begin
            failures++;
            $display("FAIL div0_entry: got v=%b d=%h op=%h err=%b, want 1 00 3 1",
                     bus.res_valid, bus.res_data, bus.res_opcode, bus.res_err);
        end
        pop_one();
        bus.cmd_opcode = 4'hA; bus.cmd_a = 8'h33; bus.cmd_b = 8'h44; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        checks++;
        if ({bus.res_valid, bus.res_data, bus.res_opcode, bus.res_err} !== {1'b1, 8'h00, 4'hA, 1'b1}) begin
            failures++;
            $display("FAIL illegal_entry: got v=%b d=%h op=%h err=%b, want 1 00 a 1",
                     bus.res_valid, bus.res_data, bus.res_opcode, bus.res_err);
        end
        pop_one();
        checks++;
        if (en_cnt !== en0) begin
            failures++; $display("FAIL reject_no_en: got %0d alu_en pulses, want 0", en_cnt - en0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [6] = '{8'h30, 8'h40, 8'h10, 8'h07, 8'h99, 8'h01};
        logic [7:0] vb [6] = '{8'h01, 8'h05, 8'h20, 8'h07, 8'h09, 8'h02};
        logic [7:0] ex [6] = '{8'h2F, 8'h3B, 8'hF0, 8'h00, 8'h90, 8'hFF};
        int   n;
        logic was_ready;
        n = 0;
        bus.res_ready = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            bus.cmd_opcode = 4'd1; bus.cmd_a = va[n]; bus.cmd_b = vb[n]; bus.cmd_valid = 1'b1;
            was_ready = bus.cmd_ready;
            tick();
            if (was_ready) n++;
        end
        checks++;
        if (n !== 4) begin failures++; $display("FAIL b2b_accepted: got %0d want 4", n); end
        checks++;
        if ({bus.cmd_ready, bus.res_count} !== {1'b0, 3'd4}) begin
            failures++;
            $display("FAIL b2b_full: got rdy=%b cnt=%0d want 0 4", bus.cmd_ready, bus.res_count);
        end
        checks++;
        if (bus.res_data !== ex[0]) begin
            failures++; $display("FAIL b2b_head0: got %h want %h", bus.res_data, ex[0]);
        end
        pop_one();
        for (int cyc = 0; cyc < 20; cyc++) begin
            bus.cmd_opcode = 4'd1; bus.cmd_a = va[n]; bus.cmd_b = vb[n]; bus.cmd_valid = 1'b1;
            was_ready = bus.cmd_ready;
            tick();
            if (was_ready) n++;
        end
        bus.cmd_valid = 1'b0;
        checks++;
        if ({n[3:0], bus.res_count} !== {4'd5, 3'd4}) begin
            failures++;
            $display("FAIL b2b_fifth: got accepted=%0d cnt=%0d want 5 4", n, bus.res_count);
        end
        for (int k = 1; k < 5; k++) begin
            checks++;
            if ({bus.res_valid, bus.res_data, bus.res_opcode, bus.res_err} !== {1'b1, ex[k], 4'd1, 1'b0}) begin
                failures++;
                $display("FAIL b2b_order%0d: got v=%b d=%h op=%h err=%b want 1 %h 1 0",
                         k, bus.res_valid, bus.res_data, bus.res_opcode, bus.res_err, ex[k]);
            end
            pop_one();
        end
        checks++;
        if (bus.res_count !== 3'd0) begin
            failures++; $display("FAIL b2b_drained: got cnt=%0d want 0", bus.res_count);
        end
    endtask

    task automatic test_accumulate();
        logic ok;
        int   en0;
        acc_val = 8'h02; acc_set = 1'b1;
        tick();
        acc_set = 1'b0;
        en0 = en_cnt;
        run_cmd(4'd4, 8'h0A, 8'h00, ok);
        checks++;
        if ({ok, bus.res_data, bus.res_opcode, bus.res_err} !== {1'b1, 8'h0C, 4'd4, 1'b0}) begin
            failures++;
            $display("FAIL adda1: got ok=%b d=%h op=%h err=%b want 1 0c 4 0",
                     ok, bus.res_data, bus.res_opcode, bus.res_err);
        end
        checks++;
        if (en_cnt - en0 !== 1) begin
            failures++; $display("FAIL adda_once: got %0d alu_en pulses want 1", en_cnt - en0);
        end
        pop_one();
        run_cmd(4'd4, 8'h10, 8'h00, ok);
        checks++;
        if ({ok, bus.res_data} !== {1'b1, 8'h1C}) begin
            failures++; $display("FAIL adda2: got ok=%b d=%h want 1 1c", ok, bus.res_data);
        end
        pop_one();
    endtask

    task automatic test_reset_midop();
        logic ok;
        bus.cmd_opcode = 4'd2; bus.cmd_a = 8'h03; bus.cmd_b = 8'h04; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.alu_en, bus.alu_opcode, bus.alu_a, bus.alu_b} !== 21'd0) begin
            failures++;
            $display("FAIL midop_alu: got en=%b op=%h a=%h b=%h want all 0",
                     bus.alu_en, bus.alu_opcode, bus.alu_a, bus.alu_b);
        end
        repeat (2) tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({bus.res_valid, bus.res_count, bus.cmd_ready} !== {1'b0, 3'd0, 1'b1}) begin
            failures++;
            $display("FAIL midop_no_push: got v=%b cnt=%0d rdy=%b want 0 0 1",
                     bus.res_valid, bus.res_count, bus.cmd_ready);
        end
        run_cmd(4'd0, 8'h11, 8'h22, ok);
        checks++;
        if ({ok, bus.res_data, bus.res_opcode, bus.res_err, bus.res_count} !== {1'b1, 8'h33, 4'd0, 1'b0, 3'd1}) begin
            failures++;
            $display("FAIL midop_next: got ok=%b d=%h op=%h err=%b cnt=%0d want 1 33 0 0 1",
                     ok, bus.res_data, bus.res_opcode, bus.res_err, bus.res_count);
        end
        pop_one();
    endtask

    initial begin
        test_reset();
        test_add();
        test_reject();
        test_back_to_back();
        test_accumulate();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
